// File: rtl/panda_pulse_pkg.sv
// Shared types and helpers for the panda_pulse delayed pulse generator.
package panda_pulse_pkg;

  localparam int PULSE_TS_W       = 32;
  localparam int QUEUE_AW_DEFAULT = 4;

  // One pending pulse is remembered only by the timestamp at which it starts.
  typedef logic [PULSE_TS_W-1:0] queue_entry_t;

  // Output pulse shaper: idle, or holding out_o high for the rest of a pulse.
  typedef enum logic {
    PULSE_IDLE = 1'b0,
    PULSE_HIGH = 1'b1
  } pulse_state_e;

  // Modular "a is strictly later than b" on the wrapping timestamp.
  // Valid while the two values are less than half the counter range apart.
  function automatic logic ts_after(input queue_entry_t a, input queue_entry_t b);
    queue_entry_t diff;
    diff = a - b;
    return (diff != '0) && !diff[PULSE_TS_W-1];
  endfunction

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic queue_entry_t width_eff(input queue_entry_t w);
    return (w == '0) ? queue_entry_t'(1) : w;
  endfunction

endpackage

// File: rtl/panda_pulse_queue.sv
// First-word-fall-through FIFO holding the start timestamps of pending pulses.
// dout always shows the oldest entry while the FIFO is not empty.
module panda_pulse_queue
  import panda_pulse_pkg::*;
#(
  parameter int AW = QUEUE_AW_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  queue_entry_t din,
  output queue_entry_t dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  queue_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a flush discards everything and wins over push/pop.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/panda_pulse.sv
// Delayed pulse generator: timestamps rising edges of inp_i, queues them and
// replays each one DELAY+1 cycles later as a pulse of WIDTH cycles on out_o.
// Edges that would overlap an earlier pulse or find the queue full are dropped.
module panda_pulse
  import panda_pulse_pkg::*;
#(
  parameter int QUEUE_AW = QUEUE_AW_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inp_i,
  input  logic                  enable_i,
  output logic                  out_o,
  output logic                  perr_o,
  input  logic [PULSE_TS_W-1:0] DELAY,
  input  logic [PULSE_TS_W-1:0] WIDTH,
  input  logic                  FORCE_RST,
  output logic [QUEUE_AW:0]     QUEUE,
  output logic [PULSE_TS_W-1:0] MISSED_CNT
);

  queue_entry_t ts_q, ts_d;
  queue_entry_t last_end_q, last_end_d;
  queue_entry_t missed_q, missed_d;
  queue_entry_t rem_q, rem_d;
  logic         inp_prev_q, inp_prev_d;
  logic         perr_q, perr_d;
  pulse_state_e state_q, state_d;

  logic          q_push;
  logic          q_pop;
  logic          q_flush;
  queue_entry_t  q_din;
  queue_entry_t  q_dout;
  logic [QUEUE_AW:0] q_count;
  logic          q_full;
  logic          q_empty;

  logic          flush;
  logic          edge_det;
  logic          fire;
  logic          out_now;
  logic          accept;
  logic          drop;
  queue_entry_t  start_ts;
  queue_entry_t  cur_width;

  panda_pulse_queue #(
    .AW (QUEUE_AW)
  ) u_queue (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Edge detection and the accept/drop decision for a newly seen edge.
  // out_now already includes a pulse that starts this cycle, so an edge can
  // never be accepted while the output is high unless it clears last_end.
  always_comb begin
    flush     = ~enable_i | FORCE_RST;
    edge_det  = inp_i & ~inp_prev_q;
    fire      = ~q_empty & (q_dout == ts_q);
    out_now   = fire | (state_q == PULSE_HIGH);
    cur_width = width_eff(WIDTH);
    start_ts  = ts_q + DELAY + queue_entry_t'(1);
    accept    = edge_det & ~flush & ~q_full &
                ((q_empty & ~out_now) | ts_after(start_ts, last_end_q));
    drop      = edge_det & ~flush & ~accept;
    q_push    = accept;
    q_pop     = fire & ~flush;
    q_flush   = flush;
    q_din     = start_ts;
  end

  // Pulse shaper: a pulse starts when the queue head matches the timestamp and
  // latches the width at that moment; rem counts high cycles still to come.
  // A new start while already high simply restarts with the newer width.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = PULSE_IDLE;
      rem_d   = '0;
    end else if (fire) begin
      if (cur_width == queue_entry_t'(1)) begin
        state_d = PULSE_IDLE;
        rem_d   = '0;
      end else begin
        state_d = PULSE_HIGH;
        rem_d   = cur_width - queue_entry_t'(1);
      end
    end else if (state_q == PULSE_HIGH) begin
      if (rem_q == queue_entry_t'(1)) begin
        state_d = PULSE_IDLE;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - queue_entry_t'(1);
      end
    end
  end

  // Timestamp, overlap bookkeeping and the saturating drop counter.
  always_comb begin
    ts_d       = ts_q + queue_entry_t'(1);
    inp_prev_d = inp_i;
    perr_d     = drop;
    last_end_d = last_end_q;
    missed_d   = missed_q;
    if (flush) begin
      last_end_d = '0;
    end else if (accept) begin
      last_end_d = start_ts + cur_width;
    end
    if (FORCE_RST) begin
      missed_d = '0;
    end else if (drop && (missed_q != '1)) begin
      missed_d = missed_q + queue_entry_t'(1);
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      last_end_q <= '0;
      missed_q   <= '0;
      rem_q      <= '0;
      inp_prev_q <= 1'b0;
      perr_q     <= 1'b0;
      state_q    <= PULSE_IDLE;
    end else begin
      ts_q       <= ts_d;
      last_end_q <= last_end_d;
      missed_q   <= missed_d;
      rem_q      <= rem_d;
      inp_prev_q <= inp_prev_d;
      perr_q     <= perr_d;
      state_q    <= state_d;
    end
  end

  assign out_o      = out_now;
  assign perr_o     = perr_q;
  assign QUEUE      = q_count;
  assign MISSED_CNT = missed_q;

endmodule

// File: tb/tb_panda_pulse.sv
// Self-checking bench for panda_pulse: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// timestamp-level model of pending pulses.
module tb_panda_pulse;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inp_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        force_rst = 1'b0;
  logic [31:0] delay_cfg = 32'd5;
  logic [31:0] width_cfg = 32'd3;
  logic        out_o;
  logic        perr_o;
  logic [4:0]  queue_cnt;
  logic [31:0] missed_cnt;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  panda_pulse #(.QUEUE_AW(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inp_i      (inp_i),
    .enable_i   (enable_i),
    .out_o      (out_o),
    .perr_o     (perr_o),
    .DELAY      (delay_cfg),
    .WIDTH      (width_cfg),
    .FORCE_RST  (force_rst),
    .QUEUE      (queue_cnt),
    .MISSED_CNT (missed_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Model: current cycle's timestamp, list of pending start times, the end of
  // the reserved output window, the active pulse interval, and drop stats.
  logic [31:0] m_ts;
  logic [31:0] m_last_end;
  logic [31:0] m_pulse_end;
  logic [31:0] m_missed;
  bit          m_pulse_on;
  bit          m_perr;
  bit          m_prev;
  logic [31:0] m_q[$];

  function automatic bit model_out();
    if (m_q.size() > 0 && m_q[0] == m_ts) return 1'b1;
    return m_pulse_on && ($signed(m_pulse_end - m_ts) > 0);
  endfunction

  function automatic void model_reset();
    m_ts = 0; m_last_end = 0; m_pulse_end = 0; m_missed = 0;
    m_pulse_on = 0; m_perr = 0; m_prev = 0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit          out_now = model_out();
    int          sz = m_q.size();
    bit          starts = (sz > 0) && (m_q[0] == m_ts);
    bit          edge_seen = inp_i && !m_prev;
    logic [31:0] weff = (width_cfg == 0) ? 32'd1 : width_cfg;
    logic [31:0] start = m_ts + delay_cfg + 32'd1;
    m_perr = 0;
    if (!enable_i || force_rst) begin
      m_q.delete();
      m_last_end = 0;
      m_pulse_on = 0;
      if (force_rst) m_missed = 0;
    end else begin
      if (starts) begin
        void'(m_q.pop_front());
        m_pulse_on  = 1;
        m_pulse_end = m_ts + weff;
      end
      if (edge_seen) begin
        if (sz < 16 && ((sz == 0 && !out_now) || $signed(start - m_last_end) > 0)) begin
          m_q.push_back(start);
          m_last_end = start + weff;
        end else begin
          m_perr = 1;
          if (m_missed != 32'hFFFF_FFFF) m_missed = m_missed + 1;
        end
      end
    end
    m_prev = inp_i;
    m_ts   = m_ts + 1;
    if (m_pulse_on && m_ts == m_pulse_end) m_pulse_on = 0;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_reset();
    else       model_step();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s ts=%0d actual=%0h required=%0h", name, m_ts, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (compare_on) begin
      checkOutput("out_o", {31'd0, out_o}, {31'd0, model_out()});
      checkOutput("perr_o", {31'd0, perr_o}, {31'd0, m_perr});
      checkOutput("QUEUE", {27'd0, queue_cnt}, 32'(m_q.size()));
      checkOutput("MISSED_CNT", missed_cnt, m_missed);
    end
  end

  // Advance to posedge+2 of the cycle whose timestamp is t.
  task automatic goto_ts(input logic [31:0] t);
    int n = 0;
    while (m_ts != t && n < 3000) begin
      @(posedge clk_i); #2;
      n++;
    end
    if (m_ts != t) begin
      checks++; errors++;
      $display("[TB] FAIL goto_ts actual=%0d required=%0d", m_ts, t);
    end
  endtask

  // sel: 0 out_o, 1 perr_o, 2 QUEUE, 3 MISSED_CNT
  task automatic check_at(input logic [31:0] t, input string name, input int sel, input logic [31:0] exp);
    logic [31:0] act;
    goto_ts(t);
    #2;
    case (sel)
      0:       act = {31'd0, out_o};
      1:       act = {31'd0, perr_o};
      2:       act = {27'd0, queue_cnt};
      default: act = missed_cnt;
    endcase
    checkOutput(name, act, exp);
  endtask

  task automatic edge_at(input logic [31:0] t);
    goto_ts(t);
    inp_i = 1'b1;
    goto_ts(t + 1);
    inp_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #2;
    rst_i = 1'b1; inp_i = 1'b0; force_rst = 1'b0; enable_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk_i); #2;
    rst_i     = ($urandom_range(0, 999) == 0);
    inp_i     = ($urandom_range(0, 3) == 0);
    enable_i  = ($urandom_range(0, 99) != 0);
    force_rst = ($urandom_range(0, 199) == 0);
    if ($urandom_range(0, 99) < 2)
      delay_cfg = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90) : $urandom_range(0, 12);
    if ($urandom_range(0, 99) < 2)
      width_cfg = $urandom_range(0, 6);
  endtask

  initial begin
    // Reset state
    do_reset();
    compare_on = 1'b1;
    #2;
    checkOutput("rst_out", {31'd0, out_o}, 32'd0);
    checkOutput("rst_perr", {31'd0, perr_o}, 32'd0);
    checkOutput("rst_queue", {27'd0, queue_cnt}, 32'd0);
    checkOutput("rst_missed", missed_cnt, 32'd0);

    // Scenario 1: single edge
    delay_cfg = 5; width_cfg = 3;
    do_reset();
    edge_at(100);
    check_at(101, "s1_queue101", 2, 1);
    check_at(105, "s1_out105", 0, 0);
    check_at(106, "s1_out106", 0, 1);
    check_at(107, "s1_queue107", 2, 0);
    check_at(108, "s1_out108", 0, 1);
    check_at(109, "s1_out109", 0, 0);

    // Scenario 2: overlapping edge dropped
    do_reset();
    edge_at(100);
    edge_at(102);
    check_at(103, "s2_perr103", 1, 1);
    check_at(103, "s2_missed", 3, 1);
    check_at(104, "s2_perr104", 1, 0);
    check_at(107, "s2_out107", 0, 1);
    check_at(109, "s2_out109", 0, 0);

    // Scenario 3: queue full
    delay_cfg = 1000; width_cfg = 1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      edge_at(100 + 4 * i);
      if (i == 15) check_at(161, "s3_queue161", 2, 16);
    end
    check_at(165, "s3_missed", 3, 1);
    check_at(165, "s3_queue165", 2, 16);
    check_at(1101, "s3_out1101", 0, 1);
    check_at(1102, "s3_out1102", 0, 0);
    check_at(1161, "s3_out1161", 0, 1);
    check_at(1162, "s3_queue1162", 2, 0);
    check_at(1165, "s3_out1165", 0, 0);

    // Scenario 4: disable mid-pulse
    delay_cfg = 2; width_cfg = 10;
    do_reset();
    edge_at(100);
    check_at(103, "s4_out103", 0, 1);
    goto_ts(105);
    enable_i = 1'b0;
    check_at(105, "s4_out105", 0, 1);
    check_at(106, "s4_out106", 0, 0);
    check_at(106, "s4_queue", 2, 0);
    edge_at(110);
    check_at(112, "s4_missed", 3, 0);
    check_at(112, "s4_out112", 0, 0);
    goto_ts(115);
    enable_i = 1'b1;

    // Scenario 5: FORCE_RST clears count, discards same-cycle edge
    delay_cfg = 5; width_cfg = 20;
    do_reset();
    edge_at(100); edge_at(102); edge_at(104); edge_at(106);
    check_at(110, "s5_missed3", 3, 3);
    goto_ts(200);
    inp_i = 1'b1; force_rst = 1'b1;
    goto_ts(201);
    inp_i = 1'b0; force_rst = 1'b0;
    check_at(201, "s5_missed0", 3, 0);
    check_at(201, "s5_queue", 2, 0);
    check_at(206, "s5_out206", 0, 0);
    check_at(207, "s5_out207", 0, 0);

    // Scenario 6: zero width/delay, then async reset mid-queue
    delay_cfg = 0; width_cfg = 0;
    do_reset();
    check_at(50, "s6_out50", 0, 0);
    inp_i = 1'b1;
    goto_ts(51);
    inp_i = 1'b0;
    check_at(51, "s6_out51", 0, 1);
    check_at(52, "s6_out52", 0, 0);
    delay_cfg = 10; width_cfg = 5;
    edge_at(60);
    edge_at(66);
    check_at(73, "s6_out73", 0, 1);
    check_at(73, "s6_queue73", 2, 1);
    rst_i = 1'b1;
    #1;
    checkOutput("s6_rst_out", {31'd0, out_o}, 32'd0);
    checkOutput("s6_rst_queue", {27'd0, queue_cnt}, 32'd0);
    checkOutput("s6_rst_perr", {31'd0, perr_o}, 32'd0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    delay_cfg = 5; width_cfg = 3;
    edge_at(100);
    check_at(101, "s6b_queue101", 2, 1);
    check_at(106, "s6b_out106", 0, 1);
    check_at(108, "s6b_out108", 0, 1);
    check_at(109, "s6b_out109", 0, 0);

    // Randomized run
    do_reset();
    for (int c = 0; c < 4000; c++) applyStimulus();
    @(posedge clk_i); #2;
    rst_i = 1'b0; inp_i = 1'b0; enable_i = 1'b1; force_rst = 1'b0;
    repeat (4) @(posedge clk_i);
    compare_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
